// File: rtl/instr_sequencer_if.sv
// Host-side bus of the instruction sequencer: the byte-serial program
// input with its control strobes, and the instruction/status outputs
// that face the 16-bit core.
interface instr_sequencer_if #(
    parameter int AW = 3
);
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        load_mode;
    logic        run;
    logic        step;
    logic        loop_en;
    logic        halt_req;
    logic [15:0] inst_out;
    logic        inst_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic        full;
    logic        overflow;
    logic        done;
    logic        busy;

    modport master (
        output byte_in, byte_valid, load_mode, run, step, loop_en, halt_req,
        input  inst_out, inst_valid, pc, prog_len, full, overflow, done, busy
    );

    modport slave (
        input  byte_in, byte_valid, load_mode, run, step, loop_en, halt_req,
        output inst_out, inst_valid, pc, prog_len, full, overflow, done, busy
    );
endinterface

// File: rtl/instr_sequencer.sv
// Byte-serial program loader and instruction issuer. Bytes arrive low
// byte first and are packed into 16-bit words in a small buffer, which is
// then replayed to the core free-running or one step at a time.
module instr_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    instr_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic          phase_q, phase_d;
    logic [7:0]    low_q, low_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   inst_out_q, inst_out_d;
    logic          inst_valid_q, inst_valid_d;
    logic          mem_we;

    logic [15:0]   mem [DEPTH];

    logic          full;
    logic          last_entry;
    logic [AW:0]   last_idx;
    logic          has_prog;

    // The word count doubles as the write pointer: its low bits index the
    // next free entry, and nothing is written once it reaches DEPTH.
    assign full       = (prog_len_q == (AW+1)'(DEPTH));
    assign has_prog   = (prog_len_q != '0);
    assign last_idx   = prog_len_q - (AW+1)'(1);
    assign last_entry = ({1'b0, pc_q} == last_idx);

    // Next-state and next-output decode for the whole sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case, so paths
        // that do not mention it hold state instead of inferring a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        prog_len_d   = prog_len_q;
        phase_d      = phase_q;
        low_d        = low_q;
        overflow_d   = overflow_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = 1'b0;
        mem_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_mode) begin
                    state_d    = S_LOAD;
                    prog_len_d = '0;
                    phase_d    = 1'b0;
                    overflow_d = 1'b0;
                end else if (bus.run && has_prog) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end else if (bus.step && has_prog) begin
                    state_d = S_STEP;
                end
            end

            S_LOAD: begin
                if (!bus.load_mode) begin
                    // A dangling low byte is simply forgotten.
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                    pc_d    = '0;
                end else if (bus.byte_valid) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else if (!phase_q) begin
                        low_d   = bus.byte_in;
                        phase_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        prog_len_d = prog_len_q + (AW+1)'(1);
                        phase_d    = 1'b0;
                    end
                end
            end

            S_RUN: begin
                if (bus.halt_req) begin
                    state_d = S_IDLE;
                end else begin
                    inst_out_d   = mem[pc_q];
                    inst_valid_d = 1'b1;
                    if (last_entry) begin
                        pc_d = '0;
                        if (!bus.loop_en) state_d = S_HALT;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end

            S_STEP: begin
                inst_out_d   = mem[pc_q];
                inst_valid_d = 1'b1;
                if (last_entry) begin
                    pc_d    = '0;
                    state_d = bus.loop_en ? S_IDLE : S_HALT;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                if (bus.load_mode) begin
                    state_d    = S_LOAD;
                    prog_len_d = '0;
                    phase_d    = 1'b0;
                    overflow_d = 1'b0;
                end else if (bus.run) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end else if (bus.step) begin
                    state_d = S_STEP;
                    pc_d    = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, independent of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            prog_len_q   <= '0;
            phase_q      <= 1'b0;
            low_q        <= 8'h00;
            overflow_q   <= 1'b0;
            inst_out_q   <= 16'h0000;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_len_q   <= prog_len_d;
            phase_q      <= phase_d;
            low_q        <= low_d;
            overflow_q   <= overflow_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Program buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; entries at or above
        // prog_len are never issued, so their contents do not matter.
        if (mem_we) begin
            mem[prog_len_q[AW-1:0]] <= {bus.byte_in, low_q};
        end
    end

    assign bus.inst_out   = inst_out_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.pc         = pc_q;
    assign bus.prog_len   = prog_len_q;
    assign bus.full       = full;
    assign bus.overflow   = overflow_q;
    assign bus.done       = (state_q == S_HALT);
    assign bus.busy       = (state_q == S_RUN);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a cycle-by-cycle vector table for
// load / run / step / half-word behaviour, then hand-written sequences for
// reset during RUN, buffer overflow, looping with halt and spaced steps.
module tb_instr_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_sequencer_if #(.AW(AW)) bus_if ();

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic        rst;
        logic        load_mode;
        logic        byte_valid;
        logic [7:0]  byte_in;
        logic        run;
        logic        step;
        logic        loop_en;
        logic        halt_req;
        logic        e_valid;
        logic [15:0] e_out;
        logic [2:0]  e_pc;
        logic [3:0]  e_len;
        logic        e_done;
        logic        e_busy;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst               = 1'b0;
        bus_if.load_mode  = 1'b0;
        bus_if.byte_valid = 1'b0;
        bus_if.byte_in    = 8'h00;
        bus_if.run        = 1'b0;
        bus_if.step       = 1'b0;
        bus_if.loop_en    = 1'b0;
        bus_if.halt_req   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Loads two words (low byte first) and returns to IDLE with pc=0.
    task automatic load_two(input logic [15:0] a, input logic [15:0] b);
        bus_if.load_mode = 1'b1;
        tick();
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in = a[7:0];  tick();
        bus_if.byte_in = a[15:8]; tick();
        bus_if.byte_in = b[7:0];  tick();
        bus_if.byte_in = b[15:8]; tick();
        bus_if.byte_valid = 1'b0;
        bus_if.load_mode  = 1'b0;
        tick();
        check("load_two.prog_len", 32'(bus_if.prog_len), 32'd2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".inst_out"},   32'(bus_if.inst_out),   32'h0);
        check({tag, ".inst_valid"}, 32'(bus_if.inst_valid), 32'h0);
        check({tag, ".pc"},         32'(bus_if.pc),         32'h0);
        check({tag, ".prog_len"},   32'(bus_if.prog_len),   32'h0);
        check({tag, ".full"},       32'(bus_if.full),       32'h0);
        check({tag, ".overflow"},   32'(bus_if.overflow),   32'h0);
        check({tag, ".done"},       32'(bus_if.done),       32'h0);
        check({tag, ".busy"},       32'(bus_if.busy),       32'h0);
    endtask

    // Pulses step once, then watches four more cycles for exactly one issue.
    task automatic step_window(input string tag, input logic [15:0] exp_word, input logic exp_done);
        int          n_valid;
        logic [15:0] word;
        n_valid = 0;
        word    = 16'h0;
        bus_if.step = 1'b1;
        tick();
        bus_if.step = 1'b0;
        if (bus_if.inst_valid) n_valid++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.inst_valid) begin
                n_valid++;
                word = bus_if.inst_out;
            end
        end
        check({tag, ".issue_count"}, 32'(n_valid), 32'd1);
        check({tag, ".word"},        32'(word),    32'(exp_word));
        check({tag, ".done"},        32'(bus_if.done), 32'(exp_done));
        check({tag, ".busy"},        32'(bus_if.busy), 32'h0);
    endtask

    initial begin
        idle_inputs();

        // rst lm bv byte run step loop halt | valid out pc len done busy full ovf
        vecs.push_back('{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h03,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h25,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd1,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h41,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd1,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h4C,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd2,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h1B,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd2,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h60,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd3,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd3,1'b0,1'b0,1'b0,1'b0});
        // run: RUN entered, first issue one edge later
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0, 1'b0,16'h0000,3'd0,4'd3,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h2503,3'd1,4'd3,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h4C41,3'd2,4'd3,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h601B,3'd0,4'd3,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h601B,3'd0,4'd3,1'b1,1'b0,1'b0,1'b0});
        // step from HALT restarts at entry 0 and lands in IDLE
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h601B,3'd0,4'd3,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h2503,3'd1,4'd3,1'b0,1'b0,1'b0,1'b0});
        // half word discarded, then run/step ignored on empty program
        vecs.push_back('{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd1,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'hAA,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd1,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h2503,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h2503,3'd0,4'd0,1'b0,1'b0,1'b0,1'b0});

        // ---- table-driven part ----
        foreach (vecs[i]) begin
            rst               = vecs[i].rst;
            bus_if.load_mode  = vecs[i].load_mode;
            bus_if.byte_valid = vecs[i].byte_valid;
            bus_if.byte_in    = vecs[i].byte_in;
            bus_if.run        = vecs[i].run;
            bus_if.step       = vecs[i].step;
            bus_if.loop_en    = vecs[i].loop_en;
            bus_if.halt_req   = vecs[i].halt_req;
            tick();
            check($sformatf("vec%0d.inst_valid", i), 32'(bus_if.inst_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.inst_out", i),   32'(bus_if.inst_out),   32'(vecs[i].e_out));
            check($sformatf("vec%0d.pc", i),         32'(bus_if.pc),         32'(vecs[i].e_pc));
            check($sformatf("vec%0d.prog_len", i),   32'(bus_if.prog_len),   32'(vecs[i].e_len));
            check($sformatf("vec%0d.done", i),       32'(bus_if.done),       32'(vecs[i].e_done));
            check($sformatf("vec%0d.busy", i),       32'(bus_if.busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d.full", i),       32'(bus_if.full),       32'(vecs[i].e_full));
            check($sformatf("vec%0d.overflow", i),   32'(bus_if.overflow),   32'(vecs[i].e_ovf));
        end
        idle_inputs();

        // ---- reset held for two cycles during looping RUN ----
        do_reset();
        load_two(16'h1234, 16'hABCD);
        bus_if.loop_en = 1'b1;
        bus_if.run = 1'b1;
        tick();
        bus_if.run = 1'b0;
        tick();
        tick();
        tick();
        check("rst_run.busy_before", 32'(bus_if.busy), 32'h1);
        rst = 1'b1;
        bus_if.run = 1'b1;
        tick();
        check_reset_outputs("rst_run.edge1");
        tick();
        check_reset_outputs("rst_run.edge2");
        rst = 1'b0;
        bus_if.run = 1'b0;
        tick();
        check_reset_outputs("rst_run.after");
        idle_inputs();

        // ---- full buffer and overflow ----
        do_reset();
        bus_if.load_mode  = 1'b1;
        tick();
        bus_if.byte_valid = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            bus_if.byte_in = 8'(8'h10 + i);
            tick();
            if (i == 2 * DEPTH - 1) begin
                check("full.full_at_last_word", 32'(bus_if.full),     32'h1);
                check("full.ovf_not_yet",       32'(bus_if.overflow), 32'h0);
            end
        end
        bus_if.byte_valid = 1'b0;
        check("full.full",     32'(bus_if.full),     32'h1);
        check("full.prog_len", 32'(bus_if.prog_len), 32'(DEPTH));
        check("full.overflow", 32'(bus_if.overflow), 32'h1);
        bus_if.load_mode = 1'b0;
        tick();
        bus_if.run = 1'b1;
        tick();
        bus_if.run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check($sformatf("full.issue%0d.valid", i), 32'(bus_if.inst_valid), 32'h1);
            check($sformatf("full.issue%0d.word", i), 32'(bus_if.inst_out),
                  32'({8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}));
        end
        check("full.last_entry", 32'(bus_if.inst_out), 32'h1F1E);
        tick();
        check("full.valid_after", 32'(bus_if.inst_valid), 32'h0);
        check("full.done",        32'(bus_if.done),       32'h1);
        check("full.ovf_sticky",  32'(bus_if.overflow),   32'h1);
        bus_if.load_mode = 1'b1;
        tick();
        check("full.reload_ovf", 32'(bus_if.overflow), 32'h0);
        check("full.reload_len", 32'(bus_if.prog_len), 32'h0);
        check("full.reload_full", 32'(bus_if.full),    32'h0);
        idle_inputs();

        // ---- looping run, halted on the fifth issue slot ----
        do_reset();
        load_two(16'h1234, 16'hABCD);
        bus_if.loop_en = 1'b1;
        bus_if.run = 1'b1;
        tick();
        bus_if.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("loop.issue%0d.valid", i), 32'(bus_if.inst_valid), 32'h1);
            check($sformatf("loop.issue%0d.word", i),  32'(bus_if.inst_out),
                  (i % 2 == 0) ? 32'h1234 : 32'hABCD);
        end
        bus_if.halt_req = 1'b1;
        tick();
        bus_if.halt_req = 1'b0;
        check("loop.halt.valid", 32'(bus_if.inst_valid), 32'h0);
        check("loop.halt.word",  32'(bus_if.inst_out),   32'hABCD);
        check("loop.halt.pc",    32'(bus_if.pc),         32'h0);
        check("loop.halt.busy",  32'(bus_if.busy),       32'h0);
        check("loop.halt.done",  32'(bus_if.done),       32'h0);
        tick();
        check("loop.idle.valid", 32'(bus_if.inst_valid), 32'h0);
        idle_inputs();

        // ---- three spaced single steps on a two-word program ----
        do_reset();
        load_two(16'h0F0E, 16'h7788);
        step_window("step1", 16'h0F0E, 1'b0);
        check("step1.pc", 32'(bus_if.pc), 32'h1);
        step_window("step2", 16'h7788, 1'b1);
        check("step2.pc", 32'(bus_if.pc), 32'h0);
        step_window("step3", 16'h0F0E, 1'b0);
        check("step3.pc", 32'(bus_if.pc), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
